// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the data memory.
//   - size_e  : access size encoding (byte / half / word, 2'b11 reserved)
//   - rsp_t   : one response beat {valid, err, rdata}
//   - lane_en : byte-lane write enables for an access size and byte offset
//   - misaligned : alignment / reserved-size check
package ram_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  // Lanes touched by an access; lane i is bits [8i+7:8i] of the word.
  function automatic logic [3:0] lane_en(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: lane_en = 4'b0001 << off;
      SZ_HALF: lane_en = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  // True for a misaligned half/word or the reserved size.
  function automatic logic misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: word-addressed storage with per-byte write enable and
// synchronous read.
//   clk   : clock
//   en    : access enable (read and/or write this edge)
//   be    : byte write enables, bit i writes lane i
//   addr  : word index
//   wdata : write data, already steered to its lanes
//   rdata : word read at the last enabled edge (old contents on a write)
module ram_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // NOTE: the storage has no reset on purpose: contents survive rst_n and a
  // reset port here would stop the array mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram.sv
// data_ram: byte-addressed data memory for the CPU load/store path.
// Byte/half/word loads and stores, sign or zero extension on loads,
// misalignment detection and an in-order response pipeline of RD_LAT cycles.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : request present
//   req_ready   : request can be accepted (low for one cycle after reset)
//   req_we      : 1 = store, 0 = load
//   req_size    : size_e encoding from ram_pkg
//   req_signed  : sign-extend byte/half loads
//   req_addr    : byte address
//   req_wdata   : store data, right-aligned
//   rsp_valid   : one-cycle response strobe, one per accepted request
//   rsp_rdata   : extended load data; 0 for stores and errors
//   rsp_err     : misaligned access or reserved size
module data_ram
  import ram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1   // legal range 1..3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WORD_AW = ADDR_W - 2;

  logic        ready_q;
  logic        accept;
  size_e       size;
  logic        bad;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic [31:0] raw_word;

  // Ready rises one edge after reset release so the first cycle out of
  // reset never accepts a request.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign req_ready = ready_q;
  assign accept    = req_valid && ready_q;
  assign size      = size_e'(req_size);
  assign bad       = misaligned(size, req_addr[1:0]);
  assign be        = (accept && req_we && !bad) ? lane_en(size, req_addr[1:0]) : 4'b0000;

  // Replicate the right-aligned store data across the word; the byte
  // enables then pick which copy lands in memory.
  // NOTE: the default assignment first keeps this block free of latches on
  // any path the case does not cover.
  always_comb begin
    wdata_lanes = req_wdata;
    case (size)
      SZ_BYTE: wdata_lanes = {4{req_wdata[7:0]}};
      SZ_HALF: wdata_lanes = {2{req_wdata[15:0]}};
      default: wdata_lanes = req_wdata;
    endcase
  end

  ram_array #(.AW(WORD_AW)) u_array (
    .clk   (clk),
    .en    (accept),
    .be    (be),
    .addr  (req_addr[ADDR_W-1:2]),
    .wdata (wdata_lanes),
    .rdata (raw_word)
  );

  // Stage 0: request attributes captured alongside the synchronous read.
  logic       s0_valid;
  logic       s0_err;
  logic       s0_load;
  size_e      s0_size;
  logic       s0_signed;
  logic [1:0] s0_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_err    <= 1'b0;
      s0_load   <= 1'b0;
      s0_size   <= SZ_BYTE;
      s0_signed <= 1'b0;
      s0_off    <= 2'b00;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_err    <= bad;
        s0_load   <= !req_we && !bad;
        s0_size   <= size;
        s0_signed <= req_signed;
        s0_off    <= req_addr[1:0];
      end
    end
  end

  // Lane steering and extension. Accesses are aligned when s0_load is set,
  // so shifting by the byte offset brings a half to bit 0 as well.
  logic [31:0] shifted;
  logic [31:0] extended;
  rsp_t        rsp0;

  always_comb begin
    shifted  = raw_word >> {s0_off, 3'b000};
    extended = raw_word;
    case (s0_size)
      SZ_BYTE: extended = {{24{s0_signed & shifted[7]}},  shifted[7:0]};
      SZ_HALF: extended = {{16{s0_signed & shifted[15]}}, shifted[15:0]};
      default: extended = raw_word;
    endcase
    rsp0.valid = s0_valid;
    rsp0.err   = s0_valid && s0_err;
    rsp0.rdata = (s0_valid && s0_load) ? extended : 32'h0;
  end

  // Remaining RD_LAT-1 cycles of latency carry the finished response.
  rsp_t rsp_q;

  if (RD_LAT <= 1) begin : g_lat1
    assign rsp_q = rsp0;
  end else begin : g_latn
    rsp_t pipe [RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RD_LAT - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= rsp0;
        for (int i = 1; i < RD_LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign rsp_q = pipe[RD_LAT-2];
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = rsp_q.rdata;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram (RD_LAT = 3). A byte-array reference
// model and an expectation queue check every response value and its cycle;
// directed vectors also carry hand-computed results.
module tb_data_ram;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  data_ram #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic [7:0]  mem_m [2**ADDR_W];
  exp_t        exp_q [$];
  logic [31:0] obs_q [$];
  int          edge_n = 0;
  logic        got;
  logic        last_err;
  logic [31:0] last_rdata;

  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                       output exp_t e);
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    n = 1 << sz;
    e.due = 0;
    e.rdata = 32'h0;
    e.err = (sz == 2'd3) || ((int'(a) % n) != 0);
    if (!e.err) begin
      if (we) begin
        for (int k = 0; k < n; k++) mem_m[int'(a) + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[int'(a) + k];
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
        if (sg && n < 4 && v[8*n-1]) v = v | ~mask;
        e.rdata = v;
      end
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      e = exp_q.pop_front();
      check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      check("rsp_rdata", rsp_rdata, e.rdata);
      got        = 1'b1;
      last_err   = rsp_err;
      last_rdata = rsp_rdata;
      obs_q.push_back(rsp_rdata);
    end else begin
      check("rsp_valid_idle", {31'h0, rsp_valid}, 32'h0);
    end
  endtask

  // One clock cycle: drive, clock, update model on accept, check #1 later.
  task automatic step(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    logic acc;
    exp_t e;
    req_valid  = v;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    acc = v && (req_ready === 1'b1);
    @(posedge clk);
    edge_n++;
    if (acc) begin
      model(we, sz, sg, a, wd, e);
      e.due = edge_n + RD_LAT - 1;
      exp_q.push_back(e);
    end
    #1;
    check_rsp();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < RD_LAT + 2; i++) idle();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [31:0] d [4];
    int w;

    vecs[0]  = '{"st_w_010_init",  1'b1, 2'b10, 1'b0, 12'h010, 32'h0000_0000, 1'b0, 32'h0};
    vecs[1]  = '{"st_w_020_init",  1'b1, 2'b10, 1'b0, 12'h020, 32'h0000_5678, 1'b0, 32'h0};
    vecs[2]  = '{"st_w_030_init",  1'b1, 2'b10, 1'b0, 12'h030, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[3]  = '{"st_w_010",       1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[4]  = '{"ld_w_010",       1'b0, 2'b10, 1'b0, 12'h010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{"st_w_010_zero",  1'b1, 2'b10, 1'b0, 12'h010, 32'h0000_0000, 1'b0, 32'h0};
    vecs[6]  = '{"st_b_013",       1'b1, 2'b00, 1'b0, 12'h013, 32'h0000_0080, 1'b0, 32'h0};
    vecs[7]  = '{"ld_bs_013",      1'b0, 2'b00, 1'b1, 12'h013, 32'h0,         1'b0, 32'hFFFF_FF80};
    vecs[8]  = '{"ld_bu_013",      1'b0, 2'b00, 1'b0, 12'h013, 32'h0,         1'b0, 32'h0000_0080};
    vecs[9]  = '{"ld_w_010_b",     1'b0, 2'b10, 1'b0, 12'h010, 32'h0,         1'b0, 32'h8000_0000};
    vecs[10] = '{"st_h_022",       1'b1, 2'b01, 1'b0, 12'h022, 32'h0000_1234, 1'b0, 32'h0};
    vecs[11] = '{"ld_hs_022",      1'b0, 2'b01, 1'b1, 12'h022, 32'h0,         1'b0, 32'h0000_1234};
    vecs[12] = '{"ld_w_020",       1'b0, 2'b10, 1'b0, 12'h020, 32'h0,         1'b0, 32'h1234_5678};
    vecs[13] = '{"ld_w_011_mis",   1'b0, 2'b10, 1'b0, 12'h011, 32'h0,         1'b1, 32'h0};
    vecs[14] = '{"st_h_031_mis",   1'b1, 2'b01, 1'b0, 12'h031, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[15] = '{"ld_w_030",       1'b0, 2'b10, 1'b0, 12'h030, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[16] = '{"ld_rsvd_040",    1'b0, 2'b11, 1'b0, 12'h040, 32'h0,         1'b1, 32'h0};
    vecs[17] = '{"ld_hs_012",      1'b0, 2'b01, 1'b1, 12'h012, 32'h0,         1'b0, 32'hFFFF_8000};
    vecs[18] = '{"ld_hu_012",      1'b0, 2'b01, 1'b0, 12'h012, 32'h0,         1'b0, 32'h0000_8000};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    got = 1'b0; last_err = 1'b0; last_rdata = 32'h0;

    // Reset state
    idle(); idle();
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err",   {31'h0, rsp_err},   32'h0);
    check("reset_req_ready", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b1;
    check("ready_low_after_release", {31'h0, req_ready}, 32'h0);
    idle();
    check("ready_high", {31'h0, req_ready}, 32'h1);

    // Table-driven directed vectors, each drained before the next
    foreach (vecs[i]) begin
      got = 1'b0;
      step(1'b1, vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata);
      w = 0;
      while (!got && w < RD_LAT + 4) begin
        idle();
        w++;
      end
      check({vecs[i].name, "_timeout"}, {31'h0, got}, 32'h1);
      check({vecs[i].name, "_err"}, {31'h0, last_err}, {31'h0, vecs[i].exp_err});
      check({vecs[i].name, "_rdata"}, last_rdata, vecs[i].exp_rdata);
    end

    // Back-to-back alternating store/load stream
    obs_q.delete();
    for (int k = 0; k < 4; k++) d[k] = $urandom;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b1, 1'b1, 2'b10, 1'b0, 12'h100 + 12'(4*(i/2)), d[i/2]);
      else            step(1'b1, 1'b0, 2'b10, 1'b0, 12'h100 + 12'(4*(i/2)), 32'h0);
    end
    drain();
    check("stream_count", obs_q.size(), 32'd8);
    if (obs_q.size() == 8) begin
      for (int k = 0; k < 4; k++) begin
        check("stream_store_rsp", obs_q[2*k], 32'h0);
        check("stream_load_raw", obs_q[2*k+1], d[k]);
      end
    end

    // Reset with two loads in flight
    step(1'b1, 1'b1, 2'b10, 1'b0, 12'h180, 32'hA5A5_1234);
    drain();
    step(1'b1, 1'b0, 2'b10, 1'b0, 12'h180, 32'h0);
    step(1'b1, 1'b0, 2'b10, 1'b0, 12'h180, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_req_ready", {31'h0, req_ready}, 32'h0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    exp_q.delete();
    idle(); idle();
    rst_n = 1'b1;
    check("rerelease_ready_low", {31'h0, req_ready}, 32'h0);
    // Request offered in the first cycle after release must not be taken
    step(1'b1, 1'b0, 2'b10, 1'b0, 12'h180, 32'h0);
    check("rerelease_ready_high", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < RD_LAT + 2; i++) idle();
    got = 1'b0;
    step(1'b1, 1'b0, 2'b10, 1'b0, 12'h180, 32'h0);
    drain();
    check("post_reset_got", {31'h0, got}, 32'h1);
    check("store_survives_reset", last_rdata, 32'hA5A5_1234);

    // Randomized traffic against the reference model
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 2'b10, 1'b0, 12'h200 + 12'(4*k), $urandom);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 12'h200 + 12'($urandom_range(0, 63)), $urandom);
    end
    drain();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
